weight_col_reader: RTL and testbench

//  Reads one weight column from the weight SRAM and streams its WEIGHT_ROWS elements to the

---
 rtl/weight_col_reader.sv | 168 ++++++++++++++++
 tb/tb_weight_col_reader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_col_reader.sv
// ============================================================================
// Module   : weight_col_reader
// Purpose  : Streams one column of the weight SRAM to the PE array over
//            valid/ready, pulsing col_done when the last row is accepted.
//            Optional stall counter port enabled by `define WCR_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_col_reader #(
    parameter int WEIGHT_ROWS          = 16,
    parameter int WEIGHT_COLS          = 3,
    parameter int DATA_WIDTH           = 8,
    parameter int COUNTER_WEIGHT_WIDTH = $clog2(WEIGHT_COLS),
    parameter int ROW_WIDTH            = $clog2(WEIGHT_ROWS),
    parameter int ADDR_WIDTH           = $clog2(WEIGHT_ROWS * WEIGHT_COLS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [COUNTER_WEIGHT_WIDTH-1:0] weight_counter,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]           mem_rd_data,
    output logic                            w_valid,
    input  logic                            w_ready,
    output logic [DATA_WIDTH-1:0]           w_data,
    output logic [ROW_WIDTH-1:0]            w_row,
    output logic                            w_last,
    output logic                            col_done,
    output logic                            busy
`ifdef WCR_STALL_CNT_EN
    ,
    output logic [15:0]                     stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                          state_q;
    logic [COUNTER_WEIGHT_WIDTH-1:0] col_q;
    logic [ROW_WIDTH-1:0]            rd_row_q;
    logic [ROW_WIDTH-1:0]            out_row_q;
    logic                            rd_done_q;
    logic                            inflight_q;

    logic [DATA_WIDTH-1:0]           fifo_q [2];
    logic                            wr_ptr_q;
    logic                            rd_ptr_q;
    logic [1:0]                      count_q;

    logic w_start_acc;
    logic w_pop;
    logic w_issue;
    logic w_last_row;

    assign w_start_acc = start && (state_q != S_STREAM);
    assign w_pop       = w_valid && w_ready;
    assign w_last_row  = (out_row_q == ROW_WIDTH'(WEIGHT_ROWS - 1));

    // Credit check: buffered + in-flight entries, minus this cycle's pop, must leave a free slot
    assign w_issue = (state_q == S_STREAM) && !rd_done_q &&
                     (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, w_pop}));

    assign mem_rd_en   = w_issue;
    assign mem_rd_addr = w_issue ?
                         ADDR_WIDTH'(32'(col_q) * 32'(WEIGHT_ROWS) + 32'(rd_row_q)) : '0;

    assign w_valid  = (count_q != 2'd0);
    assign w_data   = fifo_q[rd_ptr_q];
    assign w_row    = out_row_q;
    assign w_last   = w_valid && w_last_row;
    assign col_done = (state_q == S_DONE);
    assign busy     = (state_q == S_STREAM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            rd_row_q   <= '0;
            out_row_q  <= '0;
            rd_done_q  <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= w_issue;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        col_q     <= weight_counter;
                        rd_row_q  <= '0;
                        out_row_q <= '0;
                        rd_done_q <= 1'b0;
                        state_q   <= S_STREAM;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_STREAM: begin
                    // Row pointers saturate at the last row; rd_done_q marks all reads issued
                    if (w_issue) begin
                        if (rd_row_q == ROW_WIDTH'(WEIGHT_ROWS - 1)) begin
                            rd_done_q <= 1'b1;
                        end else begin
                            rd_row_q <= rd_row_q + 1'b1;
                        end
                    end
                    if (w_pop) begin
                        if (w_last_row) begin
                            state_q <= S_DONE;
                        end else begin
                            out_row_q <= out_row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= mem_rd_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({inflight_q, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef WCR_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else if (w_start_acc) begin
            stall_q <= 16'h0000;
        end else if (w_valid && !w_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cycles = stall_q;
`else
    logic w_unused;
    assign w_unused = w_start_acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_weight_col_reader.sv
// ============================================================================
// Module   : tb_weight_col_reader
// Purpose  : Scoreboard bench for weight_col_reader (4 rows, 3 cols, SRAM data = addr).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_col_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] weight_counter = 2'd0;
    logic       mem_rd_en;
    logic [3:0] mem_rd_addr;
    logic [7:0] mem_rd_data = 8'd0;
    logic       w_valid;
    logic       w_ready = 1'b0;
    logic [7:0] w_data;
    logic [1:0] w_row;
    logic       w_last;
    logic       col_done;
    logic       busy;
`ifdef WCR_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    weight_col_reader #(
        .WEIGHT_ROWS (4),
        .WEIGHT_COLS (3),
        .DATA_WIDTH  (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .weight_counter (weight_counter),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_data         (w_data),
        .w_row          (w_row),
        .w_last         (w_last),
        .col_done       (col_done),
        .busy           (busy)
`ifdef WCR_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, data equals address
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 8'(mem_rd_addr);
    end

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] r;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] addr_q[$];

    int tests = 0;
    int fails = 0;
    int iss = 0;
    int pops = 0;
    int done_pending = 0;
    int done_count = 0;
    bit last_hs_last = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] sv_d;
    logic [1:0] sv_r;
    logic       sv_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_sb();
        exp_q.delete();
        addr_q.delete();
        done_pending = 0;
        iss = 0;
        pops = 0;
        last_hs_last = 1'b0;
    endtask

    task automatic start_col(input int c);
        exp_t e;
        for (int r = 0; r < 4; r++) begin
            e.d = 8'(c * 4 + r);
            e.r = 2'(r);
            e.l = (r == 3);
            exp_q.push_back(e);
            addr_q.push_back(4'(c * 4 + r));
        end
        done_pending++;
        weight_counter = 2'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 200; n++) begin
            if (exp_q.size() == 0 && done_pending == 0) break;
            tick();
        end
        if (n == 200) fail_now("timeout_wait_idle");
    endtask

    task automatic wait_valid();
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (w_valid) break;
        end
        if (n == 50) fail_now("timeout_wait_valid");
    endtask

    task automatic chk_rst_outs();
        chk("rst_w_valid", 32'(w_valid), 0);
        chk("rst_col_done", 32'(col_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 0);
        chk("rst_mem_rd_addr", 32'(mem_rd_addr), 0);
        chk("rst_w_data", 32'(w_data), 0);
        chk("rst_w_row", 32'(w_row), 0);
        chk("rst_w_last", 32'(w_last), 0);
`ifdef WCR_STALL_CNT_EN
        chk("rst_stall_cycles", 32'(stall_cycles), 0);
`endif
    endtask

    // Monitor: address, data, hold-while-stalled, buffer bound and col_done legality
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] ea;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(w_valid), 1);
                chk("hold_data", 32'(w_data), 32'(sv_d));
                chk("hold_row", 32'(w_row), 32'(sv_r));
                chk("hold_last", 32'(w_last), 32'(sv_l));
            end
            if (mem_rd_en) begin
                iss++;
                if (addr_q.size() == 0) fail_now("rd_unexpected");
                else begin
                    ea = addr_q.pop_front();
                    chk("rd_addr", 32'(mem_rd_addr), 32'(ea));
                end
            end
            if (w_valid && w_ready) begin
                pops++;
                if (exp_q.size() == 0) fail_now("out_unexpected");
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(w_data), 32'(e.d));
                    chk("out_row", 32'(w_row), 32'(e.r));
                    chk("out_last", 32'(w_last), 32'(e.l));
                end
                last_hs_last = w_last;
            end
            if (mem_rd_en) chk("buffer_bound", 32'((iss - pops) <= 2), 1);
            if (col_done) begin
                done_count++;
                if (done_pending == 0) fail_now("spurious_col_done");
                else begin
                    chk("col_done_after_last", 32'(last_hs_last), 1);
                    done_pending--;
                end
                last_hs_last = 1'b0;
            end
            prev_stall = w_valid && !w_ready;
            sv_d = w_data;
            sv_r = w_row;
            sv_l = w_last;
        end
    end

    initial begin
        int d0;
        int hs;
        bit pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        #1;
        chk_rst_outs();
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Nominal column 2 with exact cycle timing
        w_ready = 1'b1;
        start_col(2);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("t2_rd_en", 32'(mem_rd_en), 32'(k <= 4));
            chk("t2_valid", 32'(w_valid), 32'(k >= 3 && k <= 6));
            chk("t2_col_done", 32'(col_done), 32'(k == 7));
            chk("t2_busy", 32'(busy), 32'(k <= 6));
            @(posedge clk);
            #1;
        end
        wait_idle();

        // Backpressure pattern on column 1
        w_ready = 1'b0;
        start_col(1);
        wait_valid();
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            w_ready = pat[i];
            tick();
        end
        w_ready = 1'b1;
        wait_idle();

        // Restart attempt while busy and counter change mid-stream are ignored
        d0 = done_count;
        start_col(2);
        tick();
        start = 1'b1;
        weight_counter = 2'd0;
        tick();
        start = 1'b0;
        wait_idle();
        repeat (3) tick();
        chk("t4_one_done", 32'(done_count - d0), 1);

        // Asynchronous reset mid-stream
        w_ready = 1'b0;
        start_col(0);
        repeat (5) tick();
        #3;
        reset = 1'b1;
        flush_sb();
        #1;
        chk_rst_outs();
        tick();
        reset = 1'b0;
        tick();

        // Reset after two handshakes of column 1, then re-stream it
        w_ready = 1'b1;
        start_col(1);
        hs = 0;
        for (int n = 0; n < 50 && hs < 2; n++) begin
            @(negedge clk);
            if (w_valid && w_ready) hs++;
        end
        if (hs < 2) fail_now("timeout_t5_handshakes");
        @(posedge clk);
        #2;
        reset = 1'b1;
        flush_sb();
        #1;
        chk_rst_outs();
        tick();
        tick();
        reset = 1'b0;
        d0 = done_count;
        tick();
        start_col(1);
        wait_idle();
        repeat (3) tick();
        chk("t5_one_done", 32'(done_count - d0), 1);

`ifdef WCR_STALL_CNT_EN
        // Stall counter: five stalled cycles, then cleared by the next start
        w_ready = 1'b0;
        start_col(0);
        wait_valid();
        repeat (5) tick();
        w_ready = 1'b1;
        wait_idle();
        tick();
        chk("t6_stall_cycles", 32'(stall_cycles), 5);
        start_col(2);
        @(negedge clk);
        chk("t6_stall_cleared", 32'(stall_cycles), 0);
        wait_idle();
`endif

        repeat (3) tick();
        chk("sb_empty", 32'(exp_q.size() + addr_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
